// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin arbiter sharing the register file write port between ALU and load writeback
module rf_write_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              hold,
    output logic              WriteEnable,
    output logic [ADDR_W-1:0] WriteAddr,
    output logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] q_addr1,
    input  logic [ADDR_W-1:0] q_addr2,
    output logic              q_hit1,
    output logic              q_hit2
);
    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(ZERO_REG);
    logic prio;
    logic open;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    always_comb begin
        open       = !reset && !hold;
        req0_ready = open && req0_valid && (!req1_valid || !prio);
        req1_ready = open && req1_valid && (!req0_valid || prio);
        sel_addr   = req0_ready ? req0_addr : req1_addr;
        sel_data   = req0_ready ? req0_data : req1_data;
    end
    function automatic logic hit(input logic [ADDR_W-1:0] q);
        return q != ZERO && ((WriteEnable && WriteAddr == q) ||
                             (req0_valid && req0_addr == q) ||
                             (req1_valid && req1_addr == q));
    endfunction
    assign q_hit1 = hit(q_addr1);
    assign q_hit2 = hit(q_addr2);
    always_ff @(posedge clk) begin
        if (reset) begin
            prio        <= 1'b0;
            WriteEnable <= 1'b0;
            WriteAddr   <= '0;
            WriteData   <= '0;
        end else begin
            WriteEnable <= 1'b0;
            if (req0_ready || req1_ready) begin
                prio        <= req0_ready;
                WriteEnable <= sel_addr != ZERO;
                WriteAddr   <= sel_addr;
                WriteData   <= sel_data;
            end
        end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed and randomized checks of rf_write_arbiter against a behavioural model
module tb_rf_write_arbiter;
    logic clk = 1'b0;
    logic reset, hold;
    logic vv [2];
    logic [4:0] aa [2];
    logic [31:0] dd [2];
    logic req0_ready, req1_ready, WriteEnable, q_hit1, q_hit2;
    logic [4:0] WriteAddr, q_addr1, q_addr2;
    logic [31:0] WriteData;
    int checks = 0, failures = 0;
    int m_prio;
    logic m_we;
    logic [4:0] m_wa;
    logic [31:0] m_wd;
    logic obs_r0, obs_r1, obs_h1;
    logic [4:0] seq [4];
    logic [4:0] nxt0, nxt1;

    always #5 clk = ~clk;

    rf_write_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(vv[0]), .req0_addr(aa[0]), .req0_data(dd[0]), .req0_ready(req0_ready),
        .req1_valid(vv[1]), .req1_addr(aa[1]), .req1_data(dd[1]), .req1_ready(req1_ready),
        .hold(hold), .WriteEnable(WriteEnable), .WriteAddr(WriteAddr), .WriteData(WriteData),
        .q_addr1(q_addr1), .q_addr2(q_addr2), .q_hit1(q_hit1), .q_hit2(q_hit2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Winner under the round-robin rule: contention goes to the priority holder.
    function automatic int exp_grant();
        if (reset || hold) return -1;
        if (vv[0] && vv[1]) return m_prio;
        if (vv[0]) return 0;
        if (vv[1]) return 1;
        return -1;
    endfunction

    function automatic logic exp_hit(input logic [4:0] q);
        if (q == 5'd31) return 1'b0;
        return (m_we && m_wa == q) || (vv[0] && aa[0] == q) || (vv[1] && aa[1] == q);
    endfunction

    task automatic req(input int n, input logic [4:0] a, input logic [31:0] d);
        vv[n] = 1'b1;
        aa[n] = a;
        dd[n] = d;
    endtask

    task automatic cycle();
        int g;
        #1;
        g = exp_grant();
        obs_r0 = req0_ready;
        obs_r1 = req1_ready;
        obs_h1 = q_hit1;
        chk("ready0", req0_ready, g == 0);
        chk("ready1", req1_ready, g == 1);
        chk("hit1", q_hit1, exp_hit(q_addr1));
        chk("hit2", q_hit2, exp_hit(q_addr2));
        chk("we", WriteEnable, m_we);
        chk("waddr", WriteAddr, m_wa);
        chk("wdata", WriteData, m_wd);
        @(posedge clk);
        if (reset) begin
            m_prio = 0; m_we = 0; m_wa = 0; m_wd = 0;
        end else if (g >= 0) begin
            m_prio = 1 - g;
            m_we = aa[g] != 5'd31;
            m_wa = aa[g];
            m_wd = dd[g];
        end else m_we = 0;
        @(negedge clk);
        if (g >= 0) vv[g] = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 6 && (vv[0] || vv[1]); i++) cycle();
        chk("drain_timeout", {vv[0], vv[1]}, 2'b00);
    endtask

    initial begin
        reset = 1; hold = 0; q_addr1 = 0; q_addr2 = 0;
        vv[0] = 0; vv[1] = 0; aa[0] = 0; aa[1] = 0; dd[0] = 0; dd[1] = 0;
        @(posedge clk);
        @(negedge clk);
        m_prio = 0; m_we = 0; m_wa = 0; m_wd = 0;
        // reset with a waiting request, then first contended grant
        req(0, 5'd3, 32'h33);
        cycle();
        chk("reset_ready0", obs_r0, 1'b0);
        cycle();
        chk("reset_we", WriteEnable, 1'b0);
        chk("reset_waddr", WriteAddr, 5'd0);
        chk("reset_wdata", WriteData, 32'd0);
        reset = 0;
        req(1, 5'd13, 32'h1313);
        cycle();
        chk("first_contended_r0", obs_r0, 1'b1);
        drain();
        // single requester
        req(1, 5'd5, 32'hDEADBEEF);
        cycle();
        chk("single_ready1", obs_r1, 1'b1);
        chk("single_we", WriteEnable, 1'b1);
        chk("single_waddr", WriteAddr, 5'd5);
        chk("single_wdata", WriteData, 32'hDEADBEEF);
        cycle();
        chk("single_we_off", WriteEnable, 1'b0);
        // contention alternates starting with req0
        nxt0 = 5'd1; nxt1 = 5'd11;
        for (int i = 0; i < 4; i++) begin
            if (!vv[0]) begin req(0, nxt0, 32'(nxt0)); nxt0++; end
            if (!vv[1]) begin req(1, nxt1, 32'(nxt1)); nxt1++; end
            cycle();
            seq[i] = WriteAddr;
        end
        chk("contend_0", seq[0], 5'd1);
        chk("contend_1", seq[1], 5'd11);
        chk("contend_2", seq[2], 5'd2);
        chk("contend_3", seq[3], 5'd12);
        drain();
        // zero register: accepted, not written, still rotates priority
        req(1, 5'd9, 32'h9);
        cycle();
        req(0, 5'd31, 32'h1234);
        q_addr1 = 5'd31;
        cycle();
        chk("zero_ready0", obs_r0, 1'b1);
        chk("zero_hit1", obs_h1, 1'b0);
        chk("zero_we", WriteEnable, 1'b0);
        req(0, 5'd4, 32'h4);
        req(1, 5'd6, 32'h6);
        cycle();
        chk("zero_prio_flip", obs_r1, 1'b1);
        drain();
        // hold freezes grants and priority
        req(1, 5'd2, 32'h2);
        cycle();
        req(0, 5'd20, 32'h20);
        req(1, 5'd21, 32'h21);
        hold = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("hold_ready", {obs_r0, obs_r1}, 2'b00);
            chk("hold_we", WriteEnable, 1'b0);
        end
        hold = 0;
        cycle();
        chk("hold_resume_r0", obs_r0, 1'b1);
        drain();
        // hazard query through wait, write and commit
        req(0, 5'd8, 32'h8);
        cycle();
        q_addr1 = 5'd7;
        req(1, 5'd9, 32'h99);
        req(0, 5'd7, 32'h77);
        cycle();
        chk("haz_wait_hit", obs_h1, 1'b1);
        chk("haz_wait_r1", obs_r1, 1'b1);
        cycle();
        chk("haz_grant_hit", obs_h1, 1'b1);
        cycle();
        chk("haz_we_hit", obs_h1, 1'b1);
        cycle();
        chk("haz_commit_hit", obs_h1, 1'b0);
        // reset while req0 would be granted
        req(0, 5'd7, 32'h777);
        reset = 1;
        cycle();
        chk("haz_reset_r0", obs_r0, 1'b0);
        chk("haz_reset_hit", obs_h1, 1'b1);
        chk("haz_reset_we", WriteEnable, 1'b0);
        reset = 0;
        drain();
        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            for (int n = 0; n < 2; n++)
                if (!vv[n] && $urandom_range(0, 99) < 60)
                    req(n, $urandom_range(0, 3) == 0 ? 5'd31 : 5'($urandom_range(0, 7)), $urandom);
            q_addr1 = $urandom_range(0, 4) == 0 ? 5'd31 : 5'($urandom_range(0, 7));
            q_addr2 = 5'($urandom_range(0, 31));
            hold = $urandom_range(0, 99) < 15;
            reset = $urandom_range(0, 99) < 3;
            cycle();
        end
        reset = 0; hold = 0;
        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
